// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad row scanner with press/release debounce
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       csync_meta;
    logic [3:0]       csync;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [DIV_W-1:0] div;
    logic [DBC_W-1:0] dbc;
    logic             col_low;

    // Once a key is latched only its own column matters; everything else is ignored.
    assign col_low = ~csync[col_idx];

    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SCAN;
            csync_meta <= 4'b1111;
            csync      <= 4'b1111;
            rows       <= 4'b1110;
            row_idx    <= 2'd0;
            col_idx    <= 2'd0;
            div        <= '0;
            dbc        <= '0;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
        end else begin
            csync_meta <= cols;
            csync      <= csync_meta;
            key_valid  <= 1'b0;
            case (state)
                SCAN: begin
                    if (div == DIV_LAST) begin
                        if (csync == 4'b1111) begin
                            row_idx <= row_idx + 2'd1;
                            rows    <= {rows[2:0], rows[3]};
                            div     <= '0;
                        end else begin
                            col_idx <= lowest_low(csync);
                            dbc     <= '0;
                            state   <= DEBOUNCE;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_low) begin
                        if (dbc == DBC_LAST) begin
                            key_code  <= {row_idx, col_idx};
                            key_valid <= 1'b1;
                            state     <= HELD;
                        end else begin
                            dbc <= dbc + DBC_W'(1);
                        end
                    end else begin
                        div   <= '0;
                        state <= SCAN;
                    end
                end
                HELD: begin
                    if (!col_low) begin
                        dbc   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!col_low) begin
                        if (dbc == DBC_LAST) begin
                            row_idx <= row_idx + 2'd1;
                            rows    <= {rows[2:0], rows[3]};
                            div     <= '0;
                            state   <= SCAN;
                        end else begin
                            dbc <= dbc + DBC_W'(1);
                        end
                    end else begin
                        state <= HELD;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
